// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module : systolic_pkg
// Brief  : Shared sizing helpers, FSM state and row type for the systolic path.
// Rev    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    localparam int DEF_MATRIX_SIZE = 2;
    localparam int DEF_DATA_SIZE   = 32;
    localparam int DEF_FIFO_DEPTH  = 4;

    function automatic int row_idx_w(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    function automatic int ptr_w(input int d);
        return $clog2(d) + 1;
    endfunction

    localparam int ROW_IDX_W = row_idx_w(DEF_MATRIX_SIZE);
    localparam int PTR_W     = ptr_w(DEF_FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAINED = 2'd2
    } state_t;

    typedef struct packed {
        logic [ROW_IDX_W-1:0]                       row;
        logic [DEF_MATRIX_SIZE*DEF_DATA_SIZE-1:0]   data;
    } row_entry_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : sync_fifo
// Brief  : Show-ahead synchronous FIFO with flush; read data is zero when empty.
// Rev    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import systolic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_ptr_w  = ptr_w(DEPTH);
    localparam int c_addr_w = c_ptr_w - 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                     (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign w_do_push = i_push & ~i_clear & (~o_full | i_pop);
    assign w_do_pop  = i_pop & ~i_clear & ~o_empty;

    assign o_pop_data = o_empty ? '0 : r_mem[r_rd_ptr[c_addr_w-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_addr_w-1:0]] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/result_deskew.sv
`default_nettype none
// ============================================================================
// Module : result_deskew
// Brief  : Re-aligns skewed column results into rows and hands them off.
// Rev    : 1.0 - initial release
// ============================================================================
module result_deskew
    import systolic_pkg::*;
#(
    parameter int MATRIX_SIZE = 2,
    parameter int DATA_SIZE   = 32,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 general_enable,
    input  logic                                 start,
    input  logic [MATRIX_SIZE-1:0]               col_valid,
    input  logic [MATRIX_SIZE*DATA_SIZE-1:0]     col_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [MATRIX_SIZE*DATA_SIZE-1:0]     out_data,
    output logic [row_idx_w(MATRIX_SIZE)-1:0]    out_row,
    output logic                                 done,
    output logic                                 overflow,
    output logic                                 skew_error
);

    localparam int c_row_w    = row_idx_w(MATRIX_SIZE);
    localparam int c_cnt_w    = $clog2(MATRIX_SIZE + 1);
    localparam int c_row_bits = MATRIX_SIZE * DATA_SIZE;

    typedef struct packed {
        logic [c_row_w-1:0]    row;
        logic [c_row_bits-1:0] data;
    } row_t;

    logic [MATRIX_SIZE-1:0] w_al_vld;
    logic [c_row_bits-1:0]  w_al_data;

    // Column j is delayed MATRIX_SIZE-1-j advance steps so all columns of a row line up.
    for (genvar j = 0; j < MATRIX_SIZE; j++) begin : g_col
        localparam int c_depth = MATRIX_SIZE - 1 - j;
        if (c_depth == 0) begin : g_nodly
            assign w_al_vld[j]                        = col_valid[j];
            assign w_al_data[j*DATA_SIZE +: DATA_SIZE] = col_data[j*DATA_SIZE +: DATA_SIZE];
        end else begin : g_dly
            logic [DATA_SIZE-1:0] r_dat [c_depth];
            logic [c_depth-1:0]   r_vld;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_vld <= '0;
                end else if (start) begin
                    r_vld <= '0;
                end else if (general_enable) begin
                    r_vld[0] <= col_valid[j];
                    for (int k = 1; k < c_depth; k++) r_vld[k] <= r_vld[k-1];
                end
            end

            always_ff @(posedge clk) begin
                if (general_enable) begin
                    r_dat[0] <= col_data[j*DATA_SIZE +: DATA_SIZE];
                    for (int k = 1; k < c_depth; k++) r_dat[k] <= r_dat[k-1];
                end
            end

            assign w_al_vld[j]                        = r_vld[c_depth-1];
            assign w_al_data[j*DATA_SIZE +: DATA_SIZE] = r_dat[c_depth-1];
        end
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_collecting;
    logic [c_cnt_w-1:0] r_push_cnt;
    logic [c_cnt_w-1:0] r_pop_cnt;
    logic               r_done;
    logic               r_overflow;
    logic               r_skew_error;

    logic w_all;
    logic w_any;
    logic w_pop;
    logic w_quota_left;
    logic w_push;
    logic w_ovf_evt;
    logic w_skew_evt;
    logic w_final_pop;
    logic w_fifo_full;
    logic w_fifo_empty;
    row_t w_fifo_wr;
    row_t w_fifo_rd;

    assign w_all        = general_enable & (&w_al_vld);
    assign w_any        = general_enable & (|w_al_vld);
    assign w_pop        = out_valid & out_ready;
    assign w_quota_left = (r_push_cnt != c_cnt_w'(MATRIX_SIZE));
    assign w_push       = ~start & w_collecting & w_all & w_quota_left & (~w_fifo_full | w_pop);
    assign w_ovf_evt    = ~start & w_collecting & w_all & w_quota_left & w_fifo_full & ~w_pop;
    // Partial rows, rows outside a job and rows beyond the job quota are all skew faults.
    assign w_skew_evt   = ~start & ((w_any & ~w_all) | (w_all & (~w_collecting | ~w_quota_left)));
    assign w_final_pop  = w_pop & (r_pop_cnt == c_cnt_w'(MATRIX_SIZE - 1));

    assign w_fifo_wr.row  = r_push_cnt[c_row_w-1:0];
    assign w_fifo_wr.data = w_al_data;

    sync_fifo #(
        .WIDTH ($bits(row_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (start),
        .i_push      (w_push),
        .i_push_data (w_fifo_wr),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_rd),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign out_valid  = ~w_fifo_empty;
    assign out_data   = w_fifo_rd.data;
    assign out_row    = w_fifo_rd.row;
    assign done       = r_done;
    assign overflow   = r_overflow;
    assign skew_error = r_skew_error;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = COLLECT;
            COLLECT: if (!start && w_final_pop) w_state_nxt = DRAINED;
            DRAINED: if (start) w_state_nxt = COLLECT;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_collecting = 1'b0;
        if (r_state == COLLECT) w_collecting = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_push_cnt   <= '0;
            r_pop_cnt    <= '0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
            r_skew_error <= 1'b0;
        end else if (start) begin
            r_push_cnt   <= '0;
            r_pop_cnt    <= '0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
            r_skew_error <= 1'b0;
        end else begin
            if (w_push)      r_push_cnt   <= r_push_cnt + c_cnt_w'(1);
            if (w_pop)       r_pop_cnt    <= r_pop_cnt + c_cnt_w'(1);
            if (w_final_pop) r_done       <= 1'b1;
            if (w_ovf_evt)   r_overflow   <= 1'b1;
            if (w_skew_evt)  r_skew_error <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_result_deskew.sv
`default_nettype none
// ============================================================================
// Module : tb_result_deskew
// Brief  : Randomized and directed check of result_deskew against a row model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_result_deskew;

    localparam int AM = 2, AD = 32, AF = 4;
    localparam int BM = 4, BD = 8,  BF = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        ge_a = 0, st_a = 0, rdy_a = 0;
    logic [1:0]  vld_a = '0;
    logic [63:0] dat_a = '0;
    logic        ov_a, done_a, ovf_a, skw_a;
    logic [63:0] od_a;
    logic [0:0]  orow_a;

    logic        ge_b = 0, st_b = 0, rdy_b = 0;
    logic [3:0]  vld_b = '0;
    logic [31:0] dat_b = '0;
    logic        ov_b, done_b, ovf_b, skw_b;
    logic [31:0] od_b;
    logic [1:0]  orow_b;

    result_deskew #(.MATRIX_SIZE(AM), .DATA_SIZE(AD), .FIFO_DEPTH(AF)) dut_a (
        .clk(clk), .reset(reset), .general_enable(ge_a), .start(st_a),
        .col_valid(vld_a), .col_data(dat_a), .out_valid(ov_a), .out_ready(rdy_a),
        .out_data(od_a), .out_row(orow_a), .done(done_a), .overflow(ovf_a),
        .skew_error(skw_a));

    result_deskew #(.MATRIX_SIZE(BM), .DATA_SIZE(BD), .FIFO_DEPTH(BF)) dut_b (
        .clk(clk), .reset(reset), .general_enable(ge_b), .start(st_b),
        .col_valid(vld_b), .col_data(dat_b), .out_valid(ov_b), .out_ready(rdy_b),
        .out_data(od_b), .out_row(orow_b), .done(done_b), .overflow(ovf_b),
        .skew_error(skw_b));

    // Reference model: a list of stored rows plus a history of enabled-step samples.
    typedef struct packed {
        logic [1:0]       row;
        logic [3:0][31:0] data;
    } mrow_t;

    mrow_t            mq     [2][8];
    int               mcnt   [2];
    int               mpushed[2];
    int               mpopped[2];
    int               mstate [2];   // 0 idle, 1 collecting, 2 drained
    bit               mdone  [2];
    bit               movf   [2];
    bit               mskew  [2];
    logic [3:0]       hvld   [2][4];
    logic [3:0][31:0] hdat   [2][4];

    logic [3:0] lh      [2];
    int         launched[2];

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_clear(input int k);
        mcnt[k] = 0; mpushed[k] = 0; mpopped[k] = 0;
        mdone[k] = 0; movf[k] = 0; mskew[k] = 0;
        for (int a = 0; a < 4; a++) begin
            hvld[k][a] = '0;
            hdat[k][a] = '0;
        end
    endtask

    task automatic model_step(input int k, input int m, input int fd, input bit ge,
                              input bit st, input logic [3:0] vld,
                              input logic [3:0][31:0] dat, input bit rdy);
        logic [3:0]       av;
        logic [3:0][31:0] ad;
        bit    all_v, any_v, pop, was_full, do_push;
        mrow_t nr;
        pop      = (mcnt[k] > 0) && rdy;
        was_full = (mcnt[k] == fd);
        if (st) begin
            model_clear(k);
            mstate[k] = 1;
            return;
        end
        av = '0; ad = '0; all_v = 0; any_v = 0; do_push = 0; nr = '0;
        if (ge) begin
            all_v = 1;
            for (int j = 0; j < m; j++) begin
                int age = m - 1 - j;
                if (age == 0) begin
                    av[j] = vld[j];
                    ad[j] = dat[j];
                end else begin
                    av[j] = hvld[k][age-1][j];
                    ad[j] = hdat[k][age-1][j];
                end
                all_v = all_v & av[j];
                any_v = any_v | av[j];
            end
            for (int a = 3; a > 0; a--) begin
                hvld[k][a] = hvld[k][a-1];
                hdat[k][a] = hdat[k][a-1];
            end
            hvld[k][0] = vld;
            hdat[k][0] = dat;
        end
        if (any_v && !all_v) mskew[k] = 1;
        else if (all_v) begin
            if (mstate[k] != 1 || mpushed[k] == m) mskew[k] = 1;
            else if (!was_full || pop) begin
                do_push = 1;
                nr.row  = 2'(mpushed[k]);
                nr.data = ad;
                mpushed[k]++;
            end else movf[k] = 1;
        end
        if (pop) begin
            for (int i = 0; i < 7; i++) mq[k][i] = mq[k][i+1];
            mcnt[k]--;
            mpopped[k]++;
            if (mpopped[k] == m) begin
                mdone[k]  = 1;
                mstate[k] = 2;
            end
        end
        if (do_push) begin
            mq[k][mcnt[k]] = nr;
            mcnt[k]++;
        end
    endtask

    task automatic compare_all();
        mrow_t ha, hb;
        ha = (mcnt[0] > 0) ? mq[0][0] : '0;
        hb = (mcnt[1] > 0) ? mq[1][0] : '0;
        check_eq("a_out_valid", ov_a, mcnt[0] > 0);
        check_eq("a_out_data", od_a, {ha.data[1], ha.data[0]});
        check_eq("a_out_row", orow_a, ha.row[0]);
        check_eq("a_done", done_a, mdone[0]);
        check_eq("a_overflow", ovf_a, movf[0]);
        check_eq("a_skew_error", skw_a, mskew[0]);
        check_eq("b_out_valid", ov_b, mcnt[1] > 0);
        check_eq("b_out_data", od_b, {hb.data[3][7:0], hb.data[2][7:0],
                                      hb.data[1][7:0], hb.data[0][7:0]});
        check_eq("b_out_row", orow_b, hb.row);
        check_eq("b_done", done_b, mdone[1]);
        check_eq("b_overflow", ovf_b, movf[1]);
        check_eq("b_skew_error", skw_b, mskew[1]);
    endtask

    task automatic tick();
        logic [3:0][31:0] da, db;
        da = '0;
        da[0] = dat_a[31:0];
        da[1] = dat_a[63:32];
        for (int j = 0; j < 4; j++) db[j] = {24'd0, dat_b[j*8 +: 8]};
        model_step(0, AM, AF, ge_a, st_a, {2'b00, vld_a}, da, rdy_a);
        model_step(1, BM, BF, ge_b, st_b, vld_b, db, rdy_b);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic rand_inputs(input int k, input int m, output bit ge, output bit st,
                               output logic [3:0] vld, output bit rdy);
        logic [3:0] mask;
        bit nl;
        mask = 4'((1 << m) - 1);
        st = 0;
        if ((mstate[k] != 1 && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) st = 1;
        ge  = ($urandom_range(0, 7) != 0);
        rdy = (k == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
        if (st) begin
            lh[k] = '0;
            launched[k] = 0;
            vld = '0;
        end else if (ge) begin
            if (launched[k] < m) nl = 1'($urandom_range(0, 1));
            else                 nl = ($urandom_range(0, 39) == 0);
            launched[k] += int'(nl);
            lh[k] = {lh[k][2:0], nl};
            vld = lh[k];
            if ($urandom_range(0, 29) == 0) vld[$urandom_range(0, m - 1)] ^= 1'b1;
        end else begin
            vld = 4'($urandom);
        end
        vld = vld & mask;
    endtask

    initial begin
        bit g, s, r;
        logic [3:0] v;
        model_clear(0); model_clear(1);
        mstate[0] = 0; mstate[1] = 0;
        lh[0] = '0; lh[1] = '0; launched[0] = 0; launched[1] = 0;
        #2;
        compare_all();
        #10 reset = 1'b1;

        // Basic job on the 2x2 instance.
        ge_a = 1; st_a = 1; rdy_a = 1; vld_a = 2'b00; tick();
        st_a = 0; vld_a = 2'b01; dat_a = {32'h0, 32'h11}; tick();
        check_eq("basic_no_early_valid", ov_a, 1'b0);
        vld_a = 2'b11; dat_a = {32'h12, 32'h21}; tick();
        check_eq("basic_row0", {ov_a, orow_a, od_a}, {1'b1, 1'b0, 64'h00000012_00000011});
        vld_a = 2'b10; dat_a = {32'h22, 32'h0}; tick();
        check_eq("basic_row1", {ov_a, orow_a, od_a}, {1'b1, 1'b1, 64'h00000022_00000021});
        vld_a = 2'b00; tick();
        check_eq("basic_done", {done_a, ov_a}, 2'b10);

        // Overflow on the 4x4 instance with a 2-deep FIFO.
        ge_b = 1; st_b = 1; rdy_b = 0; vld_b = '0; tick();
        st_b = 0;
        for (int s2 = 0; s2 < 6; s2++) begin
            lh[1] = {lh[1][2:0], (s2 < 3)};
            vld_b = lh[1];
            dat_b = $urandom;
            tick();
        end
        check_eq("ovf_flag", {ovf_b, ov_b, orow_b}, {1'b1, 1'b1, 2'd0});
        ge_b = 0; vld_b = '0; rdy_b = 1;
        repeat (3) tick();
        check_eq("ovf_no_done", {done_b, ov_b}, 2'b00);

        // Randomized jobs with stalls, aborts, backpressure and corrupted valids.
        repeat (3000) begin
            rand_inputs(0, AM, g, s, v, r);
            ge_a = g; st_a = s; rdy_a = r; vld_a = v[1:0]; dat_a = {$urandom, $urandom};
            rand_inputs(1, BM, g, s, v, r);
            ge_b = g; st_b = s; rdy_b = r; vld_b = v; dat_b = $urandom;
            tick();
        end

        // Reset in the middle of a drain.
        ge_a = 1; st_a = 1; rdy_a = 0; vld_a = 2'b00; tick();
        st_a = 0; vld_a = 2'b01; tick();
        vld_a = 2'b11; tick();
        vld_a = 2'b10; tick();
        check_eq("pre_reset_valid", ov_a, 1'b1);
        #2 reset = 1'b0;
        #1;
        check_eq("rst_a_outputs", {ov_a, orow_a, od_a, done_a, ovf_a, skw_a}, '0);
        check_eq("rst_b_outputs", {ov_b, orow_b, od_b, done_b, ovf_b, skw_b}, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/result_deskew.md
# result_deskew

Receive-side counterpart of the systolic-array scheduler. It collects the skewed per-column results leaving the bottom PE row, re-aligns each result row and buffers it in a small FIFO. It then presents whole rows downstream on a valid/ready handshake, raising `done` once all MATRIX_SIZE rows of the current job have been handed off. It sits between the array's output edge and the result writer.

## Interface
- `MATRIX_SIZE`, default 2: array dimension, equal to the number of columns and the number of result rows per job.
- `DATA_SIZE`, default 32: width of one result element.
- `FIFO_DEPTH`, default 4: number of aligned rows buffered; must be a power of two and ≥2.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `general_enable`  in  1  array advance strobe; the deskew lines shift only when it is 1.
- `start`  in  1  one-cycle pulse at job start; flushes all state.
- `col_valid`  in  MATRIX_SIZE  per-column result valid; column j arrives j cycles after column 0 for the same row.
- `col_data`  in  MATRIX_SIZE*DATA_SIZE  column j occupies bits [j*DATA_SIZE +: DATA_SIZE].
- `out_valid`  out  1  aligned row available.
- `out_ready`  in  1  downstream accepts the row.
- `out_data`  out  MATRIX_SIZE*DATA_SIZE  aligned row, same column packing as `col_data`.
- `out_row`  out  $clog2(MATRIX_SIZE) (min 1)  index of the row on `out_data`.
- `done`  out  1  all MATRIX_SIZE rows popped; sticky.
- `overflow`  out  1  sticky: an aligned row arrived while the FIFO was full, and the row was dropped.
- `skew_error`  out  1  sticky: the aligned column valids disagreed in one cycle.

## Operation
- **Deskew stage.**
  - Column j passes through a delay line of depth MATRIX_SIZE-1-j; the last column has no delay.
  - The delay lines carry data and valid.
  - They shift only when `general_enable`=1; when it is 0 they hold, and `col_valid` is ignored.
- **Alignment check.**
  - All aligned valids 1: an aligned row is formed.
  - Some aligned valids 1 but not all: set `skew_error` and discard those partial entries. No push occurs.
- **FIFO push.**
  - An aligned row is pushed when the FIFO is not full, or when a pop happens in the same cycle.
  - Otherwise set `overflow` and drop the row; the push row counter does not advance.
- **Row tagging.**
  - The push counter tags each stored row with its index 0..MATRIX_SIZE-1.
  - After MATRIX_SIZE pushes, further aligned rows are treated as errors: set `skew_error` and drop the row.
- **Pop.** A pop occurs on `out_valid && out_ready`. The pop counter increments; when it reaches MATRIX_SIZE, set `done`.
- **Output side.** It runs independently of `general_enable`: draining continues during array stalls.
- **Job control.**
  - `start` clears the delay lines, FIFO, counters, `done`, `overflow` and `skew_error` next cycle.
  - An aligned row in the `start` cycle is discarded.
  - `start` mid-job aborts the job without emitting partial rows.
- **States.** IDLE → COLLECT on `start`; COLLECT → DRAINED when `done` sets; DRAINED → COLLECT on `start`. In IDLE, aligned rows are dropped and flagged as `skew_error`.

## Timing
- **Reset values:** `out_valid`=0, `out_data`=0, `out_row`=0, `done`=0, `overflow`=0, `skew_error`=0, FSM=IDLE, all delay-line valids 0.
- **Latency:**
  - Last-column sample, with `general_enable`=1 and the FIFO empty → `out_valid`=1: 1 cycle.
  - Column-0 sample → `out_valid`: MATRIX_SIZE cycles, plus any `general_enable`=0 cycles.
- **FIFO output:** show-ahead. `out_data`/`out_row` are stable while `out_valid`=1 and `out_ready`=0.
- **Full FIFO, simultaneous push and pop:** the push is accepted and occupancy is unchanged.
- **Empty FIFO, simultaneous push and pop:** impossible, because `out_valid`=0 when the FIFO is empty.
- **FIFO pointers:** wrap modulo FIFO_DEPTH, with one extra bit for full/empty.
- **`done`:** rises the cycle after the final pop; holds until `start` or `reset`.
- **`reset` assertion:** takes effect immediately regardless of `clk`; outputs return to reset values.

## Structure
- Shared package `systolic_pkg`:
  - `ROW_IDX_W` = max(1, $clog2(MATRIX_SIZE)).
  - `PTR_W` = $clog2(FIFO_DEPTH)+1.
  - FSM state enum {IDLE, COLLECT, DRAINED}.
  - Row struct {row index, data}.
- One sub-module, `sync_fifo`: parameterized width/depth, show-ahead, with push/pop/full/empty and asynchronous active-low reset. The deskew lines stay inline as generate loops.

## Test plan
- **Basic job:** MATRIX_SIZE=2, `out_ready`=1, `start`.
  - Cycle 0: col0=0x11. Cycle 1: col0=0x21, col1=0x12. Cycle 2: col1=0x22.
  - Required: rows {0x11,0x12} idx0 and {0x21,0x22} idx1 on consecutive cycles, each 1 cycle after its last column.
  - `done`=1 one cycle after the second pop.
- **Stall:** `general_enable`=0 for 3 cycles between the col0 and col1 samples of row 0. Row is emitted intact, 3 cycles later; `col_valid` pulses during the stall are ignored.
- **Backpressure:**
  - `out_ready`=0 with FIFO_DEPTH=4 and 2 rows pushed: `out_valid` holds row 0 steady.
  - Raise `out_ready`: rows pop in order. `overflow` stays 0.
- **Overflow:** FIFO_DEPTH=2, MATRIX_SIZE=4, `out_ready`=0, 3 rows arrive.
  - Third row dropped, `overflow`=1.
  - Two rows pop once `out_ready`=1. `done` stays 0.
- **Skew error:** row with col1 valid but col0 missing → `skew_error`=1, no push.
- **Abort:** `start` after one row is in the FIFO → next cycle `out_valid`=0 and all flags 0. A fresh job then completes normally.
- **Reset:** `reset`=0 mid-drain → all outputs at reset values immediately.
